pipeline_stall_ctrl: RTL and testbench
======================================

# pipeline_stall_ctrl

Central stall/flush controller for the five-stage pipeline. It takes stall requests from ID (load-use) and from EX (multi-cycle operations) plus exception flush requests. From these it drives the 6-bit `stop_all` bus consumed by the PC register and every inter-stage register (`if_id`, `id_ex`, ...), a flush strobe, and the redirect PC. It owns the EX multi-cycle sequencing counter and two performance counters.

## Interface
- `STOP_W`, 6: width of `stop_all`; bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
- `LEN_W`, 6: width of the multi-cycle length field.
- `clock` input 1: sole clock, all state updates on rising edge.
- `reset` input 1: synchronous, active-high.
- `stall_req_id` input 1: ID load-use hazard request, valid in the cycle raised.
- `ex_op_start` input 1: one-cycle pulse; EX begins a multi-cycle op this cycle.
- `ex_op_len` input LEN_W: total EX cycles of the op, sampled with `ex_op_start`.
- `flush_req` input 1: exception/eret flush request, one cycle.
- `flush_pc` input 32: redirect target accompanying `flush_req`.
- `stop_all` output STOP_W: per-stage hold; 1 = Stop.
- `flush` output 1: clear all inter-stage registers this cycle.
- `new_pc` output 32: PC to load when `flush`=1; otherwise 0.
- `ex_op_busy` output 1: EX op in progress and not completing this cycle.
- `ex_op_final` output 1: last cycle of the EX multi-cycle op.
- `stall_count` output 32: cycles with `stop_all[0]`=1.
- `flush_count` output 16: number of flushes, saturating.

## Operation
- Stop semantics, fixed for all consumers: stage n holds when bit n=1; a bubble (zeros) enters stage n+1 when bit n=1 and bit n+1=0.
- FSM states: IDLE, MULTI. Register `remain` (LEN_W bits).
- Priority per cycle: reset > flush_req > EX multi-cycle > stall_req_id.
- flush_req=1 (any state): `flush`=1, `new_pc`=`flush_pc`, `stop_all`=000000. Next state is IDLE, and any EX op is aborted without `ex_op_final`. A same-cycle `ex_op_start` is ignored. `flush_count` increments unless it is already FFFF.
- IDLE, `ex_op_start`=1, `ex_op_len` ≥ 2: `stop_all`=001111, `ex_op_busy`=1. Next state is MULTI with `remain`=`ex_op_len`−2.
- IDLE, `ex_op_start`=1, `ex_op_len` ∈ {0,1}: single-cycle op. `ex_op_final`=1, no stall, stay IDLE.
- MULTI, `remain`≠0: `stop_all`=001111, `ex_op_busy`=1, `remain` decrements.
- MULTI, `remain`=0: `ex_op_final`=1, `stop_all`=000000 (EX result advances), next state IDLE.
- `ex_op_start` while in MULTI is ignored.
- `stall_req_id` while in MULTI is ignored; the EX stall already covers ID.
- Otherwise, `stall_req_id`=1: `stop_all`=000111 (PC/IF/ID hold, bubble into EX).
- No request: all outputs low.
- `stall_count` increments every cycle `stop_all[0]`=1 and wraps at 2^32.

## Timing
- `stop_all`, `flush`, `new_pc`, `ex_op_busy`, `ex_op_final` are combinational from current state and inputs, so a stall takes effect in the same cycle as the request.
- `remain`, state, and both counters are registered.
- An op of length L started in cycle t:
  - `stop_all`=001111 in cycles t…t+L−2.
  - `ex_op_final` in cycle t+L−1.
  - Exactly L−1 stall cycles.
- L=63 (max): 62 stall cycles, no counter overflow.
- A flush in any cycle t+k of the op: flush in t+k, IDLE at t+k+1, no final.
- While `reset`=1: all combinational outputs 0.
- On the edge where `reset`=1: state←IDLE, `remain`←0, `stall_count`←0, `flush_count`←0.
- Reset mid-op abandons the op; the first cycle after reset is IDLE with no stall.

## Test plan
- `stall_req_id`=1 for 1 cycle in IDLE → `stop_all`=000111 that cycle only, then 000000; `stall_count`=1.
- `ex_op_start` with `ex_op_len`=5 at cycle t:
  - `stop_all`=001111 and `ex_op_busy`=1 in t…t+3.
  - `ex_op_final`=1 and `stop_all`=0 at t+4.
  - `stall_count`=4.
- `ex_op_len`=1 and `ex_op_len`=0 → `ex_op_final`=1 same cycle, `stop_all`=0, state stays IDLE.
- Op len 8 started at t; `flush_req`=1 with `flush_pc`=0x00000180 at t+3:
  - At t+3: `flush`=1, `new_pc`=0x00000180, `stop_all`=0.
  - No `ex_op_final` ever; a new `ex_op_start` at t+4 is accepted.
- Same cycle `flush_req`=1, `ex_op_start`=1, `stall_req_id`=1 → only flush seen, `stop_all`=0; `flush_count` +1.
- Preload `flush_count` to FFFF via 65535 flushes (or force), flush again → stays FFFF.
- Reset asserted mid-MULTI → next cycle outputs all 0, both counters 0.

Source files
------------

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush controller for the five-stage pipeline: drives the per-stage
// hold bus, flush/redirect, sequences EX multi-cycle ops and keeps stall/flush counters.
module pipeline_stall_ctrl #(
    parameter int STOP_W = 6,
    parameter int LEN_W  = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall_req_id,
    input  logic              ex_op_start,
    input  logic [LEN_W-1:0]  ex_op_len,
    input  logic              flush_req,
    input  logic [31:0]       flush_pc,
    output logic [STOP_W-1:0] stop_all,
    output logic              flush,
    output logic [31:0]       new_pc,
    output logic              ex_op_busy,
    output logic              ex_op_final,
    output logic [31:0]       stall_count,
    output logic [15:0]       flush_count
);

    // state   | meaning
    // S_IDLE  | no EX multi-cycle op in flight; load-use stalls honoured
    // S_MULTI | EX op in flight; remain_q = stall cycles still to go before final
    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_MULTI = 1'b1
    } state_t;

    // Holding PC..EX keeps the op in EX; holding PC..ID alone bubbles EX.
    localparam logic [STOP_W-1:0] STOP_EX_OP   = STOP_W'(4'b1111);
    localparam logic [STOP_W-1:0] STOP_LOADUSE = STOP_W'(3'b111);
    localparam logic [LEN_W-1:0]  LEN_TWO      = LEN_W'(2);

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   remain_q, remain_d;
    logic [31:0]        stall_count_q, stall_count_d;
    logic [15:0]        flush_count_q, flush_count_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            remain_q      <= '0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            state_q       <= state_d;
            remain_q      <= remain_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remain_d    = remain_q;
        stop_all    = '0;
        flush       = 1'b0;
        new_pc      = '0;
        ex_op_busy  = 1'b0;
        ex_op_final = 1'b0;

        if (reset) begin
            state_d  = S_IDLE;
            remain_d = '0;
        end else if (flush_req) begin
            // Flush aborts any EX op and wins over every other request.
            flush    = 1'b1;
            new_pc   = flush_pc;
            state_d  = S_IDLE;
            remain_d = '0;
        end else if (state_q == S_MULTI) begin
            if (remain_q != '0) begin
                stop_all   = STOP_EX_OP;
                ex_op_busy = 1'b1;
                remain_d   = remain_q - 1'b1;
            end else begin
                ex_op_final = 1'b1;
                state_d     = S_IDLE;
            end
        end else if (ex_op_start) begin
            if (ex_op_len >= LEN_TWO) begin
                stop_all   = STOP_EX_OP;
                ex_op_busy = 1'b1;
                state_d    = S_MULTI;
                remain_d   = ex_op_len - LEN_TWO;
            end else begin
                ex_op_final = 1'b1;
            end
        end else if (stall_req_id) begin
            stop_all = STOP_LOADUSE;
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (stop_all[0]) begin
            stall_count_d = stall_count_q + 32'd1;
        end
        if (flush && (flush_count_q != 16'hFFFF)) begin
            flush_count_d = flush_count_q + 16'd1;
        end
    end

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: a cycle-indexed reference model queues
// the expected outputs per cycle, and a monitor compares them on the falling edge.
module tb_pipeline_stall_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall_req_id = 1'b0;
    logic        ex_op_start = 1'b0;
    logic [5:0]  ex_op_len = '0;
    logic        flush_req = 1'b0;
    logic [31:0] flush_pc = '0;
    logic [5:0]  stop_all;
    logic        flush;
    logic [31:0] new_pc;
    logic        ex_op_busy;
    logic        ex_op_final;
    logic [31:0] stall_count;
    logic [15:0] flush_count;

    always #5 clock = ~clock;

    pipeline_stall_ctrl #(.STOP_W(6), .LEN_W(6)) dut (
        .clock(clock), .reset(reset), .stall_req_id(stall_req_id),
        .ex_op_start(ex_op_start), .ex_op_len(ex_op_len),
        .flush_req(flush_req), .flush_pc(flush_pc),
        .stop_all(stop_all), .flush(flush), .new_pc(new_pc),
        .ex_op_busy(ex_op_busy), .ex_op_final(ex_op_final),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    typedef struct {
        logic [5:0]  stop;
        logic        flush;
        logic [31:0] npc;
        logic        busy;
        logic        fin;
        logic        chk_cnt;
        logic [31:0] scnt;
        logic [15:0] fcnt;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: an op is remembered by the absolute cycle of its final beat.
    int          cyc = 0;
    bit          m_active = 0;
    int          m_final_cyc = 0;
    logic [31:0] m_scnt = '0;
    int          m_fcnt = 0;
    bit          m_known = 0;

    task automatic step(input logic rst, input logic sid, input logic st,
                        input logic [5:0] len, input logic fr, input logic [31:0] fpc);
        exp_t e;
        @(posedge clock);
        #1;
        reset = rst; stall_req_id = sid; ex_op_start = st;
        ex_op_len = len; flush_req = fr; flush_pc = fpc;
        e.stop = '0; e.flush = 0; e.npc = '0; e.busy = 0; e.fin = 0;
        e.chk_cnt = m_known; e.scnt = m_scnt; e.fcnt = 16'(m_fcnt); e.cyc = cyc;
        if (rst) begin
            m_active = 0; m_scnt = '0; m_fcnt = 0; m_known = 1;
        end else begin
            if (fr) begin
                e.flush = 1; e.npc = fpc; m_active = 0;
                if (m_fcnt < 65535) m_fcnt++;
            end else if (m_active) begin
                if (cyc == m_final_cyc) begin
                    e.fin = 1; m_active = 0;
                end else begin
                    e.stop = 6'b001111; e.busy = 1;
                end
            end else if (st) begin
                if (int'(len) >= 2) begin
                    e.stop = 6'b001111; e.busy = 1;
                    m_active = 1; m_final_cyc = cyc + int'(len) - 1;
                end else begin
                    e.fin = 1;
                end
            end else if (sid) begin
                e.stop = 6'b000111;
            end
            if (e.stop[0]) m_scnt = m_scnt + 32'd1;
        end
        sbq.push_back(e);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 6'd0, 0, 32'd0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v,
                       input int c);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, c, act, exp_v);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("stop_all",    32'(stop_all),    32'(e.stop),  e.cyc);
                chk("flush",       32'(flush),       32'(e.flush), e.cyc);
                chk("new_pc",      new_pc,           e.npc,        e.cyc);
                chk("ex_op_busy",  32'(ex_op_busy),  32'(e.busy),  e.cyc);
                chk("ex_op_final", 32'(ex_op_final), 32'(e.fin),   e.cyc);
                if (e.chk_cnt) begin
                    chk("stall_count", stall_count,       e.scnt,       e.cyc);
                    chk("flush_count", 32'(flush_count),  32'(e.fcnt),  e.cyc);
                end
            end
        end
    end

    initial begin : stimulus
        logic       rst, sid, st, fr;
        logic [5:0] len;
        int         k;

        step(1, 0, 0, 6'd0, 0, 32'd0);
        step(1, 1, 1, 6'd9, 1, 32'hDEAD_BEEF);
        step(1, 0, 0, 6'd0, 0, 32'd0);
        idle(2);

        step(0, 1, 0, 6'd0, 0, 32'd0);
        idle(2);

        step(0, 0, 1, 6'd5, 0, 32'd0);
        step(0, 1, 1, 6'd7, 0, 32'd0);
        idle(5);

        step(0, 0, 1, 6'd1, 0, 32'd0);
        step(0, 0, 1, 6'd0, 0, 32'd0);
        idle(2);

        step(0, 0, 1, 6'd8, 0, 32'd0);
        idle(2);
        step(0, 0, 0, 6'd0, 1, 32'h0000_0180);
        step(0, 0, 1, 6'd3, 0, 32'd0);
        idle(10);

        step(0, 1, 1, 6'd4, 1, 32'h0000_0200);
        idle(2);

        step(0, 0, 1, 6'd63, 0, 32'd0);
        idle(64);

        step(0, 0, 1, 6'd10, 0, 32'd0);
        idle(2);
        step(1, 0, 0, 6'd0, 0, 32'd0);
        idle(3);

        for (int i = 0; i < 2500; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            fr  = ($urandom_range(0, 19) == 0);
            st  = ($urandom_range(0, 5) == 0);
            len = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 8))
                                               : 6'($urandom_range(0, 63));
            sid = ($urandom_range(0, 3) == 0);
            // A load-use request alongside a single-cycle op is left out of the mix.
            if (st && len < 6'd2) sid = 0;
            step(rst, sid, st, len, fr, $urandom);
        end
        idle(70);

        for (int i = 0; i < 65536; i++) step(0, 0, 0, 6'd0, 1, 32'h1000 + i);
        step(0, 1, 1, 6'd5, 1, 32'h0000_0180);
        idle(3);

        k = 0;
        while (k < 10 && sbq.size() > 0) begin
            @(negedge clock);
            #1;
            k++;
        end
        if (sbq.size() > 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
